// File: rtl/cabac_bin_sched_pkg.sv
// Shared types and constants for the CABAC bin scheduler: FSM state encoding,
// bit-budget constants and the helper that computes the bits a request needs.
package cabac_bin_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_DONE  = 2'd3
    } sched_state_e;

    localparam int REG_MIN_BITS_DEF = 7;
    localparam int BYTE_BITS        = 8;
    localparam int CNT_W            = 5;

    // Bits that must be staged before a request may execute.
    function automatic logic [CNT_W-1:0] need_bits(
        input logic       bypass,
        input logic [1:0] n_bin,
        input int         reg_min
    );
        return bypass ? CNT_W'(n_bin) : CNT_W'(reg_min);
    endfunction

endpackage

// File: rtl/cabac_sched_stats.sv
// Saturating statistics counters for the CABAC bin scheduler; only instantiated
// when CABAC_SCHED_STATS_EN is defined.
module cabac_sched_stats
    import cabac_bin_sched_pkg::*;
(
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         flush_i,
    input  sched_state_e state_i,
    input  logic         bypass_i,
    input  logic [1:0]   n_bin_i,
    output logic [15:0]  stat_reg_o,
    output logic [15:0]  stat_byp_o,
    output logic [15:0]  stat_stall_o
);

    logic [15:0] reg_cnt_q;
    logic [15:0] byp_cnt_q;
    logic [15:0] stall_cnt_q;
    logic [16:0] byp_sum;

    // One extra bit catches the carry so the bypass total clamps instead of wrapping.
    assign byp_sum = {1'b0, byp_cnt_q} + 17'(n_bin_i);

    always_ff @(posedge clk_i) begin
        if (reset_i || flush_i) begin
            reg_cnt_q   <= '0;
            byp_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (state_i == S_EXEC && !bypass_i && reg_cnt_q != 16'hFFFF) begin
                reg_cnt_q <= reg_cnt_q + 16'd1;
            end
            if (state_i == S_EXEC && bypass_i) begin
                byp_cnt_q <= byp_sum[16] ? 16'hFFFF : byp_sum[15:0];
            end
            if (state_i == S_FETCH && stall_cnt_q != 16'hFFFF) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
        end
    end

    assign stat_reg_o   = reg_cnt_q;
    assign stat_byp_o   = byp_cnt_q;
    assign stat_stall_o = stall_cnt_q;

endmodule

// File: rtl/cabac_bin_sched.sv
// CABAC bin scheduler: stages bitstream bytes until a regular bin or bypass group
// can be decoded, then drives one decoder step. Statistics: CABAC_SCHED_STATS_EN.
module cabac_bin_sched
    import cabac_bin_sched_pkg::*;
#(
    parameter int BIN_WIDTH    = 3,
    parameter int REG_MIN_BITS = REG_MIN_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_bypass,
    input  logic [1:0]           req_n_bin,
    input  logic [7:0]           req_pstate,
    output logic                 dec_bypass,
    output logic [1:0]           dec_n_bin,
    output logic [7:0]           dec_pstate,
    output logic                 dec_en,
    output logic                 dec_init,
    input  logic [BIN_WIDTH-1:0] dec_bin,
    input  logic [2:0]           dec_numbits,
    output logic                 byte_req,
    input  logic                 byte_valid,
    output logic                 byte_load,
    output logic                 res_valid,
    output logic [BIN_WIDTH-1:0] res_bin,
    output logic [2:0]           res_nbits,
    output logic [15:0]          stat_reg,
    output logic [15:0]          stat_byp,
    output logic [15:0]          stat_stall,
    output sched_state_e         dbg_state,
    output logic [CNT_W-1:0]     dbg_bit_cnt
);

    // Handshake: a request transfers on a rising edge where req_valid && req_ready;
    // req_ready is high exactly while the FSM sits in IDLE.

    sched_state_e         state_q;
    logic [CNT_W-1:0]     bit_cnt_q;
    logic                 dec_bypass_q;
    logic [1:0]           dec_n_bin_q;
    logic [7:0]           dec_pstate_q;
    logic                 dec_en_q;
    logic                 dec_init_q;
    logic                 byte_req_q;
    logic                 res_valid_q;
    logic [BIN_WIDTH-1:0] res_bin_q;
    logic [2:0]           res_nbits_q;

    logic [CNT_W-1:0]     need_req;
    logic [CNT_W-1:0]     need_cur;
    logic [CNT_W-1:0]     cnt_loaded;
    logic [2:0]           consumed;
    logic [CNT_W-1:0]     cnt_after_exec;

    assign need_req = need_bits(req_bypass, req_n_bin, REG_MIN_BITS);
    assign need_cur = need_bits(dec_bypass_q, dec_n_bin_q, REG_MIN_BITS);

    // A byte offered while flush or reset is active is dropped, never counted.
    assign byte_load  = byte_req_q && byte_valid && !flush && !reset;
    assign cnt_loaded = byte_load ? bit_cnt_q + CNT_W'(BYTE_BITS) : bit_cnt_q;

    assign consumed       = dec_bypass_q ? {1'b0, dec_n_bin_q} : dec_numbits;
    assign cnt_after_exec = (CNT_W'(consumed) > bit_cnt_q) ? '0
                                                           : bit_cnt_q - CNT_W'(consumed);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            bit_cnt_q    <= '0;
            dec_bypass_q <= 1'b0;
            dec_n_bin_q  <= '0;
            dec_pstate_q <= '0;
            dec_en_q     <= 1'b0;
            dec_init_q   <= 1'b1;
            byte_req_q   <= 1'b0;
            res_valid_q  <= 1'b0;
            res_bin_q    <= '0;
            res_nbits_q  <= '0;
        end else if (flush) begin
            state_q      <= S_IDLE;
            bit_cnt_q    <= '0;
            dec_en_q     <= 1'b0;
            dec_init_q   <= 1'b1;
            byte_req_q   <= 1'b0;
            res_valid_q  <= 1'b0;
            res_bin_q    <= '0;
            res_nbits_q  <= '0;
        end else begin
            dec_en_q    <= 1'b0;
            dec_init_q  <= 1'b0;
            byte_req_q  <= 1'b0;
            res_valid_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        dec_bypass_q <= req_bypass;
                        dec_n_bin_q  <= req_n_bin;
                        dec_pstate_q <= req_pstate;
                        // An empty bypass group has nothing to decode.
                        if (req_bypass && req_n_bin == 2'd0) begin
                            state_q     <= S_DONE;
                            res_valid_q <= 1'b1;
                            res_bin_q   <= '0;
                            res_nbits_q <= '0;
                        end else if (bit_cnt_q >= need_req) begin
                            state_q  <= S_EXEC;
                            dec_en_q <= 1'b1;
                        end else begin
                            state_q    <= S_FETCH;
                            byte_req_q <= 1'b1;
                        end
                    end
                end
                S_FETCH: begin
                    bit_cnt_q <= cnt_loaded;
                    if (cnt_loaded >= need_cur) begin
                        state_q  <= S_EXEC;
                        dec_en_q <= 1'b1;
                    end else begin
                        byte_req_q <= 1'b1;
                    end
                end
                S_EXEC: begin
                    res_bin_q   <= dec_bin;
                    res_nbits_q <= consumed;
                    bit_cnt_q   <= cnt_after_exec;
                    state_q     <= S_DONE;
                    res_valid_q <= 1'b1;
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready   = (state_q == S_IDLE);
    assign dec_bypass  = dec_bypass_q;
    assign dec_n_bin   = dec_n_bin_q;
    assign dec_pstate  = dec_pstate_q;
    assign dec_en      = dec_en_q;
    assign dec_init    = dec_init_q;
    assign byte_req    = byte_req_q;
    assign res_valid   = res_valid_q;
    assign res_bin     = res_bin_q;
    assign res_nbits   = res_nbits_q;
    assign dbg_state   = state_q;
    assign dbg_bit_cnt = bit_cnt_q;

`ifdef CABAC_SCHED_STATS_EN
    cabac_sched_stats u_stats (
        .clk_i        (clk),
        .reset_i      (reset),
        .flush_i      (flush),
        .state_i      (state_q),
        .bypass_i     (dec_bypass_q),
        .n_bin_i      (dec_n_bin_q),
        .stat_reg_o   (stat_reg),
        .stat_byp_o   (stat_byp),
        .stat_stall_o (stat_stall)
    );
`else
    assign stat_reg   = '0;
    assign stat_byp   = '0;
    assign stat_stall = '0;
`endif

endmodule
